// File: rtl/acia_rx_if.sv
// Serial line, parity setup and holding-register handshake of the ACIA receive stage.
// The master side is the bus/line side. The slave side is the receiver.
interface acia_rx_if;
    logic       RX;
    logic       R_PME;
    logic [1:0] R_PMC;
    logic       RXTAKEN;
    logic [7:0] RXDATA;
    logic       RXFULL;
    logic       PERR;
    logic       FERR;
    logic       OVRN;

    modport master (
        output RX, R_PME, R_PMC, RXTAKEN,
        input  RXDATA, RXFULL, PERR, FERR, OVRN
    );

    modport slave (
        input  RX, R_PME, R_PMC, RXTAKEN,
        output RXDATA, RXFULL, PERR, FERR, OVRN
    );
endinterface

// File: rtl/acia_rx.sv
// ACIA serial receiver: 16x oversampled deframing of 8-bit LSB-first characters with optional parity.
// Latency: the holding register loads at the mid-stop sample, 152/168 BCLK after start detect (+1 with ACIA_RX_MAJORITY_EN).
// Backpressure: a single holding register; a completion while RXFULL is set without RXTAKEN drops the character and sets OVRN.
module acia_rx (
    input  logic        BCLK,
    input  logic        RESET,
    acia_rx_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] r_clk;
    logic [2:0] r_bitcnt;
    logic       r_par;
    logic       par_pend;
    logic [7:0] shift;

    logic       sync1;
    logic       rxs;
    logic       hist;

    logic [7:0] rxdata_q;
    logic       rxfull_q;
    logic       perr_q;
    logic       ferr_q;
    logic       ovrn_q;

    logic       samp_bit;
    logic       par_exp;
    logic       start_edge;
    logic       at_sample;
    logic       at_end;

`ifdef ACIA_RX_MAJORITY_EN
    localparam logic [3:0] SAMPLE_PT = 4'd8;
    logic hist2;

    // hist holds rxs from r_clk==7, hist2 from r_clk==6
    assign samp_bit = (rxs & hist) | (rxs & hist2) | (hist & hist2);

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) hist2 <= 1'b1;
        else        hist2 <= hist;
    end
`else
    localparam logic [3:0] SAMPLE_PT = 4'd7;

    assign samp_bit = rxs;
`endif

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= bus.RX;
            rxs   <= sync1;
            hist  <= rxs;
        end
    end

    assign start_edge = hist & ~rxs;
    assign at_sample  = (r_clk == SAMPLE_PT);
    assign at_end     = (r_clk == 4'hF);

    always_comb begin
        par_exp = 1'b0;
        case (bus.R_PMC)
            2'b00:   par_exp = ~r_par;
            2'b01:   par_exp = r_par;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            r_clk    <= 4'd0;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            par_pend <= 1'b0;
            shift    <= 8'h00;
            rxdata_q <= 8'h00;
            rxfull_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovrn_q   <= 1'b0;
        end else begin
            // A completion on the same edge overrides this release below
            if (bus.RXTAKEN) begin
                rxfull_q <= 1'b0;
                ovrn_q   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    r_clk    <= 4'd0;
                    r_bitcnt <= 3'd0;
                    r_par    <= 1'b0;
                    par_pend <= 1'b0;
                    if (start_edge) state <= START;
                end

                START: begin
                    r_clk <= r_clk + 4'd1;
                    if (at_sample && samp_bit) begin
                        state <= IDLE;
                    end else if (at_end) begin
                        state <= DATA;
                        r_clk <= 4'd0;
                    end
                end

                DATA: begin
                    r_clk <= r_clk + 4'd1;
                    if (at_sample) begin
                        shift <= {samp_bit, shift[7:1]};
                        r_par <= r_par ^ samp_bit;
                    end
                    if (at_end) begin
                        r_clk <= 4'd0;
                        if (r_bitcnt != 3'd7) r_bitcnt <= r_bitcnt + 3'd1;
                        else if (bus.R_PME)   state    <= PARITY;
                        else                  state    <= STOP;
                    end
                end

                PARITY: begin
                    r_clk <= r_clk + 4'd1;
                    if (at_sample) par_pend <= (samp_bit != par_exp);
                    if (at_end) begin
                        r_clk <= 4'd0;
                        state <= STOP;
                    end
                end

                STOP: begin
                    r_clk <= r_clk + 4'd1;
                    // Completing mid-stop leaves half a bit to catch a back-to-back start edge
                    if (at_sample) begin
                        state <= IDLE;
                        if (!rxfull_q || bus.RXTAKEN) begin
                            rxdata_q <= shift;
                            perr_q   <= bus.R_PME & par_pend;
                            ferr_q   <= ~samp_bit;
                            rxfull_q <= 1'b1;
                        end else begin
                            ovrn_q   <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RXDATA = rxdata_q;
    assign bus.RXFULL = rxfull_q;
    assign bus.PERR   = perr_q;
    assign bus.FERR   = ferr_q;
    assign bus.OVRN   = ovrn_q;

endmodule

// File: tb/tb_acia_rx.sv
// Directed frames on RX; expected characters queued at issue and checked by a monitor on each holding-register load.
module tb_acia_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

`ifdef ACIA_RX_MAJORITY_EN
    localparam int LOAD_OFS = 155;
`else
    localparam int LOAD_OFS = 154;
`endif

    logic BCLK;
    logic RESET;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic prev_full;

    acia_rx_if bus();

    acia_rx dut (
        .BCLK  (BCLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A load is RXFULL appearing, or RXFULL still set on an edge where RXTAKEN was high
    always @(posedge BCLK) begin
        #2;
        if (RESET === 1'b1) begin
            if (bus.RXFULL === 1'b1 && (prev_full !== 1'b1 || bus.RXTAKEN === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_load: got data %0h, no character expected", bus.RXDATA);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rxdata", {24'd0, bus.RXDATA}, {24'd0, e.d});
                    chk("perr",   {31'd0, bus.PERR},   {31'd0, e.p});
                    chk("ferr",   {31'd0, bus.FERR},   {31'd0, e.f});
                end
            end
        end
        prev_full = bus.RXFULL;
    end

    task automatic send_frame(input logic [7:0] d, input logic pme, input logic pbit,
                              input logic stopb, input int glitch, input int take_at,
                              input int ncyc);
        logic [10:0] bits;
        int nb;
        int lim;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pme) begin
            bits[9]  = pbit;
            bits[10] = stopb;
            nb = 11;
        end else begin
            bits[9] = stopb;
            nb = 10;
        end
        lim = (ncyc > 0) ? ncyc : nb * 16;
        bus.R_PME = pme;
        for (int i = 0; i < lim; i++) begin
            @(negedge BCLK);
            bus.RX      = (i == glitch) ? 1'b0 : bits[i / 16];
            bus.RXTAKEN = (i == take_at);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge BCLK);
            bus.RX      = 1'b1;
            bus.RXTAKEN = 1'b0;
        end
    endtask

    task automatic take();
        @(negedge BCLK);
        bus.RXTAKEN = 1'b1;
        @(negedge BCLK);
        bus.RXTAKEN = 1'b0;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_rxdata"}, {24'd0, bus.RXDATA}, 32'h0);
        chk({tag, "_rxfull"}, {31'd0, bus.RXFULL}, 32'h0);
        chk({tag, "_perr"},   {31'd0, bus.PERR},   32'h0);
        chk({tag, "_ferr"},   {31'd0, bus.FERR},   32'h0);
        chk({tag, "_ovrn"},   {31'd0, bus.OVRN},   32'h0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        prev_full   = 1'b0;
        RESET       = 1'b0;
        bus.RX      = 1'b1;
        bus.R_PME   = 1'b0;
        bus.R_PMC   = 2'b00;
        bus.RXTAKEN = 1'b0;
        repeat (4) @(negedge BCLK);
        chk_outputs_reset("reset");
        RESET = 1'b1;
        idle(10);

        // Plain character, no parity
        exp_q.push_back('{d: 8'h55, p: 1'b0, f: 1'b0});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        chk("full_after_55", {31'd0, bus.RXFULL}, 32'd1);
        chk("ovrn_after_55", {31'd0, bus.OVRN},   32'd0);
        take();
        chk("full_after_take", {31'd0, bus.RXFULL}, 32'd0);

        // 0xA5 has four ones: odd parity wants 1, even wants 0; the bit is sent as 0
        bus.R_PMC = 2'b00;
        exp_q.push_back('{d: 8'hA5, p: 1'b1, f: 1'b0});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        take();
        bus.R_PMC = 2'b01;
        exp_q.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        take();

        // Mark parity sent as 0 is an error
        bus.R_PMC = 2'b10;
        exp_q.push_back('{d: 8'h0F, p: 1'b1, f: 1'b0});
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        take();

        // Framing error, then line held low: exactly one character
        exp_q.push_back('{d: 8'h3C, p: 1'b0, f: 1'b1});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, 0);
        repeat (640) begin
            @(negedge BCLK);
            bus.RX = 1'b0;
        end
        idle(40);
        chk("break_full", {31'd0, bus.RXFULL}, 32'd1);
        take();
        idle(40);
        chk("break_single_frame", {31'd0, bus.RXFULL}, 32'd0);

        // Back-to-back without RXTAKEN: second character lost
        exp_q.push_back('{d: 8'h11, p: 1'b0, f: 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        chk("ovrn_data",  {24'd0, bus.RXDATA}, 32'h11);
        chk("ovrn_set",   {31'd0, bus.OVRN},   32'd1);
        chk("ovrn_full",  {31'd0, bus.RXFULL}, 32'd1);
        take();
        chk("ovrn_clr",      {31'd0, bus.OVRN},   32'd0);
        chk("ovrn_full_clr", {31'd0, bus.RXFULL}, 32'd0);

        // RXTAKEN coincident with the second completion
        exp_q.push_back('{d: 8'h11, p: 1'b0, f: 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        exp_q.push_back('{d: 8'h22, p: 1'b0, f: 1'b0});
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1, LOAD_OFS, 0);
        idle(8);
        chk("coinc_data", {24'd0, bus.RXDATA}, 32'h22);
        chk("coinc_ovrn", {31'd0, bus.OVRN},   32'd0);
        chk("coinc_full", {31'd0, bus.RXFULL}, 32'd1);
        take();

        // Short glitch on an idle line is a false start
        repeat (3) begin
            @(negedge BCLK);
            bus.RX = 1'b0;
        end
        idle(200);
        chk("glitch_no_full", {31'd0, bus.RXFULL}, 32'd0);

        // One-cycle glitch at the bit-0 sample point of 0xFF
`ifdef ACIA_RX_MAJORITY_EN
        exp_q.push_back('{d: 8'hFF, p: 1'b0, f: 1'b0});
`else
        exp_q.push_back('{d: 8'hFE, p: 1'b0, f: 1'b0});
`endif
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 24, -1, 0);
        idle(8);
        take();

        // Reset in the middle of bit 4, with a character still held
        exp_q.push_back('{d: 8'h5A, p: 1'b0, f: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        chk("pre_reset_full", {31'd0, bus.RXFULL}, 32'd1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, -1, 5 * 16 + 8);
        @(negedge BCLK);
        RESET  = 1'b0;
        bus.RX = 1'b1;
        repeat (3) @(negedge BCLK);
        chk_outputs_reset("midframe_reset");
        RESET = 1'b1;
        idle(40);
        chk("post_reset_idle", {31'd0, bus.RXFULL}, 32'd0);
        exp_q.push_back('{d: 8'h81, p: 1'b0, f: 1'b0});
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, -1, 0);
        idle(8);
        chk("post_reset_full", {31'd0, bus.RXFULL}, 32'd1);
        take();
        idle(20);

        chk("expected_all_received", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
